// File: rtl/pss_pkg.sv
// Shared definitions for the PSS peak tracker: mode encoding, FSM states, channel-index width.
package pss_pkg;

  localparam logic [1:0] MODE_SEARCH = 2'd0;
  localparam logic [1:0] MODE_FIND   = 2'd1;
  localparam logic [1:0] MODE_PAUSE  = 2'd2;

  typedef enum logic [1:0] {
    PAUSE_ST  = 2'd0,
    SEARCH_ST = 2'd1,
    TRACK_ST  = 2'd2
  } pss_state_e;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pss_score_argmax.sv
// Registered argmax over masked channel scores; ties resolve to the lowest channel index.
module pss_score_argmax #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned SCORE_DW = 32,
  parameter int unsigned CH_W     = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_CH-1:0]          cand_i,
  input  logic [NUM_CH*SCORE_DW-1:0] score_i,
  output logic [CH_W-1:0]            idx_o,
  output logic                       valid_o
);

  logic [CH_W-1:0]     best_idx_c;
  logic [SCORE_DW-1:0] best_score_c;
  logic                found_c;

  // Strict greater-than keeps the earliest (lowest) index on equal scores
  always_comb begin
    best_idx_c   = '0;
    best_score_c = '0;
    found_c      = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cand_i[k] && (!found_c || (score_i[k*SCORE_DW +: SCORE_DW] > best_score_c))) begin
        best_idx_c   = CH_W'(k);
        best_score_c = score_i[k*SCORE_DW +: SCORE_DW];
        found_c      = 1'b1;
      end
    end
  end

  // Index holds its last winner so it doubles as the locked channel
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= found_c;
      if (found_c) idx_o <= best_idx_c;
    end
  end

endmodule

// File: rtl/pss_peak_tracker.sv
// PSS peak arbitration with post-lock time tracking and loss-of-lock detection.
// Optional PSS_SCORE_THRESHOLD_EN adds min_score_i gating of candidate scores.
module pss_peak_tracker
  import pss_pkg::*;
#(
  parameter  int unsigned NUM_CH       = 3,
  parameter  int unsigned SCORE_DW     = 32,
  parameter  int unsigned SSB_INTERVAL = 38400,
  parameter  int unsigned TRACK_TOL    = 100,
  parameter  int unsigned MAX_MISSES   = 3,
  localparam int unsigned CH_W         = ch_w(NUM_CH),
  localparam int unsigned CNT_W        = $clog2(SSB_INTERVAL + TRACK_TOL + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       s_axis_in_tvalid,
  input  logic [1:0]                 mode_i,
  input  logic [CH_W-1:0]            requested_N_id_2_i,
  input  logic [NUM_CH-1:0]          peak_detected_i,
  input  logic [NUM_CH*SCORE_DW-1:0] score_i,
`ifdef PSS_SCORE_THRESHOLD_EN
  input  logic [SCORE_DW-1:0]        min_score_i,
`endif
  output logic                       correlator_en_o,
  output logic [CH_W-1:0]            N_id_2_o,
  output logic                       N_id_2_valid_o,
  output logic                       tracking_o,
  output logic [CNT_W-1:0]           sample_cnt_o,
  output logic [3:0]                 miss_cnt_o,
  output logic                       lost_o
);

  localparam int unsigned WIN_LO = SSB_INTERVAL - TRACK_TOL;
  localparam int unsigned WIN_HI = SSB_INTERVAL + TRACK_TOL;

  pss_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [3:0]        miss_d;
  logic              lost_d;
  logic [NUM_CH-1:0] sel_c, thr_c, cand_c;
  logic              accept_c, pause_req_c, in_win_c, hit_c;

  assign pause_req_c = (mode_i >= MODE_PAUSE);
  assign in_win_c    = (sample_cnt_o >= CNT_W'(WIN_LO)) && (sample_cnt_o <= CNT_W'(WIN_HI));
  assign hit_c       = |cand_c;

  // Candidate mask: channel selection, score threshold, window and pause gating
  always_comb begin
    sel_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (state_q == TRACK_ST)         sel_c[k] = (N_id_2_o == CH_W'(k));
      else if (mode_i == MODE_SEARCH)  sel_c[k] = 1'b1;
      else if (mode_i == MODE_FIND)    sel_c[k] = (requested_N_id_2_i == CH_W'(k));
    end
`ifdef PSS_SCORE_THRESHOLD_EN
    thr_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      thr_c[k] = (score_i[k*SCORE_DW +: SCORE_DW] >= min_score_i);
    end
`else
    thr_c = '1;
`endif
    accept_c = !pause_req_c &&
               ((state_q == SEARCH_ST) || ((state_q == TRACK_ST) && in_win_c));
    cand_c   = peak_detected_i & sel_c & thr_c & {NUM_CH{accept_c}};
  end

  pss_score_argmax #(
    .NUM_CH   (NUM_CH),
    .SCORE_DW (SCORE_DW),
    .CH_W     (CH_W)
  ) u_argmax (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .cand_i  (cand_c),
    .score_i (score_i),
    .idx_o   (N_id_2_o),
    .valid_o (N_id_2_valid_o)
  );

  // Next state and counter updates; a miss is taken when a sample arrives past the window end
  always_comb begin
    state_d = state_q;
    cnt_d   = sample_cnt_o;
    miss_d  = miss_cnt_o;
    lost_d  = 1'b0;
    case (state_q)
      PAUSE_ST: begin
        cnt_d  = '0;
        miss_d = '0;
        if (!pause_req_c) state_d = SEARCH_ST;
      end
      SEARCH_ST: begin
        if (pause_req_c) begin
          state_d = PAUSE_ST;
        end else if (hit_c) begin
          state_d = TRACK_ST;
          cnt_d   = '0;
          miss_d  = '0;
        end
      end
      TRACK_ST: begin
        if (pause_req_c) begin
          state_d = PAUSE_ST;
          cnt_d   = '0;
          miss_d  = '0;
        end else if (hit_c) begin
          cnt_d  = '0;
          miss_d = '0;
        end else if (s_axis_in_tvalid) begin
          if (sample_cnt_o == CNT_W'(WIN_HI)) begin
            if ((miss_cnt_o + 4'd1) == 4'(MAX_MISSES)) begin
              lost_d  = 1'b1;
              state_d = SEARCH_ST;
              cnt_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_cnt_o + 4'd1;
              cnt_d  = CNT_W'(TRACK_TOL);
            end
          end else begin
            cnt_d = sample_cnt_o + CNT_W'(1);
          end
        end
      end
      default: state_d = PAUSE_ST;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= PAUSE_ST;
      sample_cnt_o    <= '0;
      miss_cnt_o      <= '0;
      lost_o          <= 1'b0;
      correlator_en_o <= 1'b0;
      tracking_o      <= 1'b0;
    end else begin
      state_q         <= state_d;
      sample_cnt_o    <= cnt_d;
      miss_cnt_o      <= miss_d;
      lost_o          <= lost_d;
      correlator_en_o <= (state_d != PAUSE_ST);
      tracking_o      <= (state_d == TRACK_ST);
    end
  end

endmodule

// File: doc/pss_peak_tracker.md
Name: pss_peak_tracker

Overview:
- Successor to the fixed three-correlator PSS peak decision logic.
- Sits between NUM_CH PSS correlator + peak detector pairs and the CFO/SSS stages.
- Arbitrates simultaneous peaks by highest score instead of rejecting them.
- Adds a time-tracking mode: after lock, only peaks inside a window around the expected SSB position are accepted, misses are counted, and loss of lock is declared after MAX_MISSES consecutive misses.

Parameters:
- NUM_CH, 3, number of N_id_2 hypotheses / correlator channels (2..8).
- SCORE_DW, 32, width of each channel score.
- SSB_INTERVAL, 38400, expected input samples between PSS peaks (20 ms at 1.92 MSps).
- TRACK_TOL, 100, half-width of the acceptance window, in samples.
- MAX_MISSES, 3, consecutive missed windows before lock is lost (1..15).
- CH_W, derived: max(1, $clog2(NUM_CH)).

Ports:
- clk_i, in, 1, clock.
- reset_i, in, 1, synchronous reset, active high.
- s_axis_in_tvalid, in, 1, input sample strobe; advances the sample counter.
- mode_i, in, 2, 0 SEARCH, 1 FIND, 2 PAUSE, 3 treated as PAUSE.
- requested_N_id_2_i, in, CH_W, channel considered in FIND mode.
- peak_detected_i, in, NUM_CH, per-channel peak pulse.
- score_i, in, NUM_CH*SCORE_DW, per-channel score, unsigned; channel k at bits [k*SCORE_DW +: SCORE_DW].
- correlator_en_o, out, 1, enables the correlators.
- N_id_2_o, out, CH_W, selected/locked channel.
- N_id_2_valid_o, out, 1, one-cycle pulse per accepted peak.
- tracking_o, out, 1, high while in TRACK.
- sample_cnt_o, out, $clog2(SSB_INTERVAL+TRACK_TOL+1), samples since the last accepted or predicted peak.
- miss_cnt_o, out, 4, consecutive misses.
- lost_o, out, 1, one-cycle pulse on loss of lock.

Behaviour:
- Reset: all outputs 0; state = PAUSE_ST; next state after reset is decided by mode_i.
- States: SEARCH_ST, TRACK_ST, PAUSE_ST.
- Candidate set:
  - SEARCH mode: all channels with peak_detected_i set.
  - FIND mode: only requested_N_id_2_i.
  - TRACK_ST: only the locked N_id_2_o.
- Arbitration: among candidates, take the maximum score; on a tie, the lowest index wins. Registered, so N_id_2_valid_o asserts exactly 1 cycle after peak_detected_i.
- PAUSE_ST:
  - correlator_en_o=0, no valid pulses, counters cleared, tracking_o=0.
  - Leaves to SEARCH_ST when mode_i is 0 or 1.
- SEARCH_ST:
  - correlator_en_o=1.
  - Any candidate: register it, pulse valid, sample_cnt<=0, miss_cnt<=0, go TRACK_ST.
- TRACK_ST:
  - sample_cnt increments per s_axis_in_tvalid.
  - Window is SSB_INTERVAL-TRACK_TOL <= sample_cnt <= SSB_INTERVAL+TRACK_TOL.
  - Locked-channel peak inside window: pulse valid, sample_cnt<=0, miss_cnt<=0.
  - Peaks outside the window are ignored, including other channels.
  - sample_cnt reaching SSB_INTERVAL+TRACK_TOL with no accepted peak: miss_cnt++, sample_cnt<=TRACK_TOL (re-centred on the predicted position).
  - If the incremented miss_cnt == MAX_MISSES: lost_o pulse, clear counters, go SEARCH_ST.
- Simultaneous events:
  - Peak on the final window sample counts as a hit, not a miss.
  - mode_i → PAUSE wins over any peak in the same cycle (no valid pulse).
  - mode change between SEARCH and FIND while in TRACK_ST is ignored until lock is lost.
- Reset mid-track: returns to PAUSE_ST with all outputs 0 on the next edge.

Optional Feature:
- Macro: PSS_SCORE_THRESHOLD_EN.
- Defined: adds port min_score_i (in, SCORE_DW). A candidate is valid only if score >= min_score_i; a below-threshold peak in the window counts as absent.
- Undefined: no port; every peak_detected_i bit is a candidate.

Decomposition:
- Package pss_pkg: mode encoding constants (SEARCH/FIND/PAUSE), state typedef, CH_W helper function.
- Sub-module pss_score_argmax: parametrised NUM_CH/SCORE_DW, candidate mask + scores → registered index + valid, lowest-index tie rule.

Test Plan:
- SEARCH, peaks on ch1 (score 500) and ch2 (score 900) in the same cycle → N_id_2_o=2, one valid pulse 1 cycle later, tracking_o=1.
- Equal scores 700 on ch0 and ch2 → N_id_2_o=0.
- TRACK locked on ch0, peaks at 38400, 38350, 38500 samples after the previous peak → all accepted, miss_cnt_o=0; peak at 38550 → ignored, miss_cnt_o=1 at counter 38500.
- Locked, then no peaks for 3 windows (MAX_MISSES=3) → lost_o pulses once, tracking_o=0, back in SEARCH; next peak on ch1 relocks.
- FIND with requested=1, peaks on ch0 (score 900) and ch1 (score 100) → N_id_2_o=1; mode_i=2 mid-track → correlator_en_o=0 next cycle, counters 0.
- With PSS_SCORE_THRESHOLD_EN, min_score_i=300, ch2 peak score 299 → no valid; score 300 → accepted.
